// File: rtl/d_drain_arbiter.sv
// Drain arbiter: round-robin pops from the D0/D1 FIFOs under credit flow control,
// merging the popped words onto one tagged output bus with idle and count status.

module d_drain_credit #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [CW-1:0] max_i,
  input  logic          pop_i,
  input  logic          ret_i,
  output logic          has_credit_o,
  output logic          err_o
);
  logic [CW-1:0] credit_q, credit_d, max_q;
  logic          err_q, err_d;

  always_comb begin
    credit_d = credit_q;
    err_d    = err_q;
    if (load_i) begin
      credit_d = max_i;
    end else if (pop_i && !ret_i) begin
      credit_d = credit_q - 1'b1;
    end else if (ret_i && !pop_i) begin
      // A return with the counter already full is a protocol slip; keep the count.
      if (credit_q == max_q) err_d = 1'b1;
      else                   credit_d = credit_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_q <= '0;
      max_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      credit_q <= credit_d;
      err_q    <= err_d;
      if (load_i) max_q <= max_i;
    end
  end

  assign has_credit_o = |credit_q;
  assign err_o        = err_q;
endmodule

module d_drain_arbiter #(
  parameter int data_width   = 6,
  parameter int credit_width = 4,
  parameter int count_width  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    init,
  input  logic [credit_width-1:0] max_credit_D0,
  input  logic [credit_width-1:0] max_credit_D1,
  input  logic                    empty_fifo_D0,
  input  logic                    empty_fifo_D1,
  input  logic [data_width-1:0]   data_out_D0,
  input  logic [data_width-1:0]   data_out_D1,
  input  logic                    credit_ret_D0,
  input  logic                    credit_ret_D1,
  output logic                    D0_pop,
  output logic                    D1_pop,
  output logic [data_width-1:0]   data_out,
  output logic                    valid_out,
  output logic                    dest_out,
  output logic                    idle_out,
  output logic                    credit_err,
  output logic [count_width-1:0]  count_D0,
  output logic [count_width-1:0]  count_D1
);
  localparam int NUM_DEST = 2;
  localparam int STAGES   = 1;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_ACTIVE} state_e;

  state_e                                    state_q;
  logic                                      rr_last_q;
  logic [STAGES:0]                           vld_pipe_q;
  logic                                      dest_s1_q;
  logic [data_width-1:0]                     data_out_q;
  logic                                      dest_out_q;
  logic                                      idle_q;
  logic [count_width-1:0]                    cnt0_q, cnt1_q;

  logic [NUM_DEST-1:0]                       empty, ret, pop, elig, has_credit, err;
  logic [NUM_DEST-1:0][credit_width-1:0]     max_cr;
  logic [NUM_DEST-1:0][data_width-1:0]       fifo_data;
  logic                                      in_init, load;

  assign empty     = {empty_fifo_D1, empty_fifo_D0};
  assign max_cr    = {max_credit_D1, max_credit_D0};
  assign fifo_data = {data_out_D1, data_out_D0};
  assign in_init   = (state_q == S_INIT);
  assign load      = in_init && !init;

  genvar g;
  generate
    for (g = 0; g < NUM_DEST; g++) begin : g_lane
      assign ret[g]  = (g == 0 ? credit_ret_D0 : credit_ret_D1) && !in_init;
      assign elig[g] = !empty[g] && has_credit[g] && !in_init;
    end
  endgenerate

  d_drain_credit #(.CW(credit_width)) u_credit [NUM_DEST-1:0] (
    .clk          (clk),
    .rst_n        (reset),
    .load_i       ({NUM_DEST{load}}),
    .max_i        (max_cr),
    .pop_i        (pop),
    .ret_i        (ret),
    .has_credit_o (has_credit),
    .err_o        (err)
  );

  // On contention the destination that did not win last time gets the pop.
  always_comb begin
    pop = elig;
    if (&elig) pop = rr_last_q ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_INIT;
      rr_last_q  <= 1'b1;
      vld_pipe_q <= '0;
      dest_s1_q  <= 1'b0;
      data_out_q <= '0;
      dest_out_q <= 1'b0;
      idle_q     <= 1'b0;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[STAGES-1:0], |pop};
      if (|pop) begin
        rr_last_q <= pop[1];
        dest_s1_q <= pop[1];
      end
      // FIFO read data is present the cycle after its pop.
      if (vld_pipe_q[0]) begin
        data_out_q <= fifo_data[dest_s1_q];
        dest_out_q <= dest_s1_q;
        if (dest_s1_q) cnt1_q <= cnt1_q + 1'b1;
        else           cnt0_q <= cnt0_q + 1'b1;
      end
      idle_q <= (state_q == S_IDLE) && !(|vld_pipe_q) && !(|pop);
      if (!init) begin
        state_q <= S_INIT;
      end else begin
        case (state_q)
          S_INIT:   state_q <= S_IDLE;
          S_IDLE:   if (|elig) state_q <= S_ACTIVE;
          S_ACTIVE: if (!(|elig) && !(|vld_pipe_q)) state_q <= S_IDLE;
          default:  state_q <= S_INIT;
        endcase
      end
    end
  end

  assign D0_pop     = pop[0];
  assign D1_pop     = pop[1];
  assign data_out   = data_out_q;
  assign valid_out  = vld_pipe_q[STAGES];
  assign dest_out   = dest_out_q;
  assign idle_out   = idle_q;
  assign credit_err = |err;
  assign count_D0   = cnt0_q;
  assign count_D1   = cnt1_q;
endmodule
